syncnt_decoder: RTL and testbench

- Monitors the 4-bit value stream of the team's synchronous up/down step counter and recovers the counter's control inputs: direction (down) and step size (step).
- Compares each new sample with the previous one (modulo 2^W) and classifies the change as +1, +2, -1, -2, hold or illegal.
- Declares lock after LOCK_CNT consecutive consistent deltas and flags protocol errors.
- Sits on the receiving side of a counter bus, as a checker/decoder in testbenches and in self-checking top levels.

---
 rtl/syncnt_pkg.sv | 47 ++++
 rtl/syncnt_delta.sv | 21 ++
 rtl/syncnt_decoder.sv | 136 +++++++++++++
 tb/tb_syncnt_decoder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/syncnt_pkg.sv
// syncnt_pkg: shared types and helpers for the step-counter decoder.
//   delta_class_t : classification of one sample-to-sample delta
//   state_t       : decoder tracking state
//   classify()    : maps a modulo-2^w delta onto delta_class_t
//   class_of(), class_down(), class_step() : convert between a class
//                   and the recovered (down, step) pair
package syncnt_pkg;

   typedef enum logic [2:0] {HOLD, UP1, UP2, DN1, DN2, ILLEGAL} delta_class_t;

   typedef enum logic [1:0] {EMPTY, TRACK, LOCKED} state_t;

   // d is the delta already reduced modulo 2^w and zero-extended to 16 bits.
   // The +1/+2 checks come first so that very narrow counters (w=2) where
   // +2 and -2 alias resolve to the upward class.
   function automatic delta_class_t classify(input logic [15:0] d,
                                             input int unsigned w);
      logic [16:0] modulus;
      logic [16:0] dx;
      modulus = 17'd1 << w;
      dx      = {1'b0, d};
      if (dx == 17'd0)                 return HOLD;
      else if (dx == 17'd1)            return UP1;
      else if (dx == 17'd2)            return UP2;
      else if (dx == modulus - 17'd1)  return DN1;
      else if (dx == modulus - 17'd2)  return DN2;
      else                             return ILLEGAL;
   endfunction

   function automatic delta_class_t class_of(input logic down, input logic step);
      case ({down, step})
         2'b00:   return UP1;
         2'b01:   return UP2;
         2'b10:   return DN1;
         default: return DN2;
      endcase
   endfunction

   function automatic logic class_down(input delta_class_t c);
      return (c == DN1) || (c == DN2);
   endfunction

   function automatic logic class_step(input delta_class_t c);
      return (c == UP2) || (c == DN2);
   endfunction

endpackage

// File: rtl/syncnt_delta.sv
// syncnt_delta: combinational delta extractor and classifier.
//   cnt  : current counter sample (W bits)
//   prev : previously accepted sample (W bits)
//   cls  : class of (cnt - prev) mod 2^W
module syncnt_delta
   import syncnt_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0]  cnt,
   input  logic [W-1:0]  prev,
   output delta_class_t  cls
);

   logic [W-1:0] d;

   // Subtraction at width W wraps naturally, giving the modulo-2^W delta.
   assign d   = cnt - prev;
   assign cls = classify(16'(d), W);

endmodule

// File: rtl/syncnt_decoder.sv
// syncnt_decoder: watches the value stream of an up/down step counter and
// recovers its direction and step size, reports lock and protocol errors.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   en     : cnt holds a valid sample this cycle
//   cnt    : observed counter value (W bits)
//   down   : recovered direction, 1 = counting down
//   step   : recovered step, 1 = step of 2, 0 = step of 1
//   hold   : last delta was zero
//   locked : LOCK_CNT consecutive identical legal deltas seen
//   err    : one-cycle pulse on an illegal delta or a broken lock
module syncnt_decoder
   import syncnt_pkg::*;
#(
   parameter int W        = 4,
   parameter int LOCK_CNT = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] cnt,
   output logic         down,
   output logic         step,
   output logic         hold,
   output logic         locked,
   output logic         err
);

   localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

   state_t       state, state_n;
   logic [W-1:0] prev, prev_n;
   logic [3:0]   run, run_n;
   logic         down_n, step_n, hold_n, locked_n, err_n;
   delta_class_t cls, cur_cls;

   syncnt_delta #(.W(W)) u_delta (
      .cnt  (cnt),
      .prev (prev),
      .cls  (cls)
   );

   // The class currently being tracked is exactly what down/step encode.
   // After reset or an illegal delta run is 0, so "same class" and
   // "new class" both yield run=1 and the comparison is harmless.
   assign cur_cls = class_of(down, step);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= EMPTY;
         prev   <= '0;
         run    <= '0;
         down   <= 1'b0;
         step   <= 1'b0;
         hold   <= 1'b0;
         locked <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         prev   <= prev_n;
         run    <= run_n;
         down   <= down_n;
         step   <= step_n;
         hold   <= hold_n;
         locked <= locked_n;
         err    <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      prev_n   = prev;
      run_n    = run;
      down_n   = down;
      step_n   = step;
      hold_n   = hold;
      locked_n = locked;
      err_n    = 1'b0;

      if (en) begin
         prev_n = cnt;
         case (state)
            EMPTY: state_n = TRACK;

            TRACK: begin
               case (cls)
                  HOLD: hold_n = 1'b1;
                  ILLEGAL: begin
                     err_n  = 1'b1;
                     run_n  = '0;
                     hold_n = 1'b0;
                  end
                  default: begin
                     down_n = class_down(cls);
                     step_n = class_step(cls);
                     hold_n = 1'b0;
                     if (cls == cur_cls)
                        run_n = (run >= LOCK_N) ? LOCK_N : run + 4'd1;
                     else
                        run_n = 4'd1;
                     if (run_n == LOCK_N) begin
                        locked_n = 1'b1;
                        state_n  = LOCKED;
                     end
                  end
               endcase
            end

            LOCKED: begin
               if (cls == cur_cls) begin
                  hold_n = 1'b0;
               end else if (cls == HOLD) begin
                  hold_n = 1'b1;
               end else begin
                  // Lock broken: fall back to tracking, restarting the run
                  // from the new class when it is legal.
                  err_n    = 1'b1;
                  locked_n = 1'b0;
                  hold_n   = 1'b0;
                  state_n  = TRACK;
                  if (cls == ILLEGAL) begin
                     run_n = '0;
                  end else begin
                     run_n  = 4'd1;
                     down_n = class_down(cls);
                     step_n = class_step(cls);
                  end
               end
            end

            default: state_n = EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_syncnt_decoder.sv
// tb_syncnt_decoder: directed scenarios plus randomized counter streams,
// compared every cycle against a behavioural model of the decoder.
module tb_syncnt_decoder;

   localparam int W  = 4;
   localparam int LC = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en  = 1'b0;
   logic [W-1:0] cnt = '0;
   logic         down, step, hold, locked, err;

   int vectors = 0;
   int miscompares = 0;
   bit checking = 0;

   syncnt_decoder #(.W(W), .LOCK_CNT(LC)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .cnt    (cnt),
      .down   (down),
      .step   (step),
      .hold   (hold),
      .locked (locked),
      .err    (err)
   );

   always #5 clk = ~clk;

   // Behavioural model: the tracked trend is a signed step (+1,+2,-1,-2).
   int m_prev, m_dir, m_run, m_sd;
   bit m_have, m_hold, m_locked, m_err;

   always @(posedge clk) begin
      if (rst) begin
         m_have = 0; m_prev = 0; m_dir = 1; m_run = 0;
         m_hold = 0; m_locked = 0; m_err = 0;
      end else if (!en) begin
         m_err = 0;
      end else if (!m_have) begin
         m_have = 1; m_err = 0; m_prev = int'(cnt);
      end else begin
         m_sd = (int'(cnt) - m_prev + 16) % 16;
         if (m_sd >= 8) m_sd = m_sd - 16;
         m_err = 0;
         if (m_sd == 0) begin
            m_hold = 1;
         end else if (m_sd > 2 || m_sd < -2) begin
            m_hold = 0; m_err = 1; m_locked = 0; m_run = 0;
         end else if (m_locked) begin
            m_hold = 0;
            if (m_sd != m_dir) begin
               m_err = 1; m_locked = 0; m_run = 1; m_dir = m_sd;
            end
         end else begin
            m_hold = 0;
            if (m_sd == m_dir) m_run = (m_run + 1 > LC) ? LC : m_run + 1;
            else               m_run = 1;
            m_dir = m_sd;
            if (m_run == LC) m_locked = 1;
         end
         m_prev = int'(cnt);
      end
   end

   task automatic chk(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (checking) begin
         chk("down",   down,   logic'(m_dir < 0));
         chk("step",   step,   logic'(m_dir == 2 || m_dir == -2));
         chk("hold",   hold,   m_hold);
         chk("locked", locked, m_locked);
         chk("err",    err,    m_err);
      end
   end

   task automatic smp(input int v);
      en  = 1'b1;
      cnt = W'(v);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      en = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      en  = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      int v, trend, r;
      do_reset();
      checking = 1;
      chk("rst_locked", locked, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_down", down, 1'b0);
      chk("rst_hold", hold, 1'b0);

      // Up by 1 across the wrap
      smp(13); smp(14); smp(15);
      chk("up1_notyet", locked, 1'b0);
      smp(0);
      chk("up1_locked", locked, 1'b1);
      chk("up1_down", down, 1'b0);
      chk("up1_step", step, 1'b0);
      smp(1);
      chk("up1_err", err, 1'b0);
      chk("up1_model", logic'(m_locked), 1'b1);

      // Down by 2 across the wrap
      do_reset();
      smp(2); smp(0); smp(14);
      chk("dn2_notyet", locked, 1'b0);
      smp(12);
      chk("dn2_locked", locked, 1'b1);
      chk("dn2_down", down, 1'b1);
      chk("dn2_step", step, 1'b1);
      chk("dn2_model", logic'(m_dir == -2), 1'b1);

      // Hold while locked, then direction change and relock
      do_reset();
      smp(2); smp(3); smp(4); smp(5);
      smp(5);
      chk("hold_set", hold, 1'b1);
      chk("hold_locked", locked, 1'b1);
      smp(5);
      smp(6);
      chk("hold_clr", hold, 1'b0);
      chk("hold_stay", locked, 1'b1);
      smp(7);
      smp(6);
      chk("dir_err", err, 1'b1);
      chk("dir_unlock", locked, 1'b0);
      chk("dir_down", down, 1'b1);
      chk("dir_step", step, 1'b0);
      smp(5);
      chk("dir_errpulse", err, 1'b0);
      smp(4);
      chk("dir_relock", locked, 1'b1);

      // Illegal jump followed by en gaps
      do_reset();
      smp(3);
      chk("first_noerr", err, 1'b0);
      smp(9);
      chk("ill_err", err, 1'b1);
      chk("ill_model_run", logic'(m_run == 0), 1'b1);
      idle(3);
      chk("gap_err", err, 1'b0);
      chk("gap_locked", locked, 1'b0);

      // Reset mid-run while locked
      do_reset();
      smp(1); smp(2); smp(3); smp(4);
      chk("pre_rst_locked", locked, 1'b1);
      do_reset();
      chk("mid_rst_locked", locked, 1'b0);
      chk("mid_rst_down", down, 1'b0);
      chk("mid_rst_hold", hold, 1'b0);
      smp(8);
      chk("post_rst_noerr", err, 1'b0);
      smp(13);
      chk("post_rst_ill", err, 1'b1);

      // Randomized streams: mostly a steady trend with occasional holds,
      // direction changes, illegal jumps, en gaps and resets.
      do_reset();
      v = 0;
      trend = 1;
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            do_reset();
         end else if (r < 15) begin
            idle(1);
         end else begin
            r = int'($urandom_range(0, 99));
            if (r < 6) begin
               case ($urandom_range(0, 3))
                  0: trend = 1;
                  1: trend = 2;
                  2: trend = -1;
                  default: trend = -2;
               endcase
               v = v + trend;
            end else if (r < 14) begin
               v = v;
            end else if (r < 20) begin
               v = int'($urandom_range(0, 15));
            end else begin
               v = v + trend;
            end
            v = (v % 16 + 16) % 16;
            smp(v);
         end
      end

      idle(2);
      checking = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
